mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared CPU package: memory-controller state encoding, requester ids and
// access-size codes, plus the zero-fill mask used when returning load data.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MM = 1'b1
  } mem_owner_e;

  // Size code is byte count minus one; code 2 is a legal 3-byte access.
  localparam logic [1:0] CU_BYTE = 2'd0;
  localparam logic [1:0] CU_HALF = 2'd1;
  localparam logic [1:0] CU_WORD = 2'd3;

  function automatic logic [31:0] size_mask(input logic [1:0] cu);
    case (cu)
      CU_BYTE: size_mask = 32'h0000_00FF;
      CU_HALF: size_mask = 32'h0000_FFFF;
      2'd2:    size_mask = 32'h00FF_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between instruction fetch and the memory
// stage, serialising each multi-byte access into one RAM byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_e,
  input  logic [31:0] if_a,
  output logic [31:0] if_n_o,
  output logic        if_ok,
  input  logic        mm_e,
  input  logic        mm_wr,
  input  logic [31:0] mm_a,
  input  logic [1:0]  mm_cu,
  input  logic [31:0] mm_n_i,
  output logic [31:0] mm_n_o,
  output logic        mm_ok,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_wr,
  input  logic [7:0]  ram_q
);

  mem_state_e      state_q;
  mem_owner_e      owner_q;
  logic [31:0]     base_q;
  logic [1:0]      cu_q;
  logic [1:0]      idx_q;
  logic            wr_q;
  logic [3:0][7:0] wdata_q;
  logic [3:0][7:0] rdata_q;

  logic [31:0]     if_n_q;
  logic [31:0]     mm_n_q;
  logic            if_ok_q;
  logic            mm_ok_q;
  logic [31:0]     ram_a_q;
  logic [7:0]      ram_d_q;
  logic            ram_wr_q;

  logic [1:0]      idx_d;
  logic [1:0]      cap_lane;
  logic [3:0][7:0] final_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_d      = idx_q + 2'd1;
    cap_lane   = idx_q - 2'd1;
    final_data = rdata_q;
    final_data[cu_q] = ram_q;
    final_data = final_data & size_mask(cu_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      base_q   <= '0;
      cu_q     <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      if_n_q   <= '0;
      mm_n_q   <= '0;
      if_ok_q  <= 1'b0;
      mm_ok_q  <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
      ram_wr_q <= 1'b0;
    end else begin
      if_ok_q <= 1'b0;
      mm_ok_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mm_e) begin
            owner_q  <= OWN_MM;
            base_q   <= mm_a;
            cu_q     <= mm_cu;
            wr_q     <= mm_wr;
            wdata_q  <= mm_n_i;
            rdata_q  <= '0;
            idx_q    <= 2'd0;
            ram_a_q  <= mm_a;
            ram_d_q  <= mm_n_i[7:0];
            ram_wr_q <= mm_wr;
            state_q  <= ST_XFER;
          end else if (if_e) begin
            owner_q  <= OWN_IF;
            base_q   <= if_a;
            cu_q     <= CU_WORD;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            idx_q    <= 2'd0;
            ram_a_q  <= if_a;
            ram_d_q  <= 8'h00;
            ram_wr_q <= 1'b0;
            state_q  <= ST_XFER;
          end
        end

        ST_XFER: begin
          // ram_q now carries the byte issued on the previous XFER cycle.
          if (!wr_q && idx_q != 2'd0) rdata_q[cap_lane] <= ram_q;
          idx_q <= idx_d;
          if (idx_q == cu_q) begin
            ram_wr_q <= 1'b0;
            if (wr_q) begin
              state_q <= ST_DONE;
              if (owner_q == OWN_MM) mm_ok_q <= 1'b1;
              else                   if_ok_q <= 1'b1;
            end else begin
              state_q <= ST_CAPT;
            end
          end else begin
            ram_a_q <= base_q + {30'd0, idx_d};
            ram_d_q <= wdata_q[idx_d];
          end
        end

        ST_CAPT: begin
          state_q <= ST_DONE;
          if (owner_q == OWN_MM) begin
            mm_n_q  <= final_data;
            mm_ok_q <= 1'b1;
          end else begin
            if_n_q  <= final_data;
            if_ok_q <= 1'b1;
          end
        end

        // Stores leave n_o untouched; only loads assemble return data.
        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_n_o = if_n_q;
  assign if_ok  = if_ok_q;
  assign mm_n_o = mm_n_q;
  assign mm_ok  = mm_ok_q;
  assign ram_a  = ram_a_q;
  assign ram_d  = ram_d_q;
  assign ram_wr = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a table of load/store vectors against a
// byte RAM model, plus hand-written fetch, arbitration and reset sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_e;
  logic [31:0] if_a;
  logic [31:0] if_n_o;
  logic        if_ok;
  logic        mm_e;
  logic        mm_wr;
  logic [31:0] mm_a;
  logic [1:0]  mm_cu;
  logic [31:0] mm_n_i;
  logic [31:0] mm_n_o;
  logic        mm_ok;
  logic [31:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_wr;
  logic [7:0]  ram_q;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .if_e   (if_e),
    .if_a   (if_a),
    .if_n_o (if_n_o),
    .if_ok  (if_ok),
    .mm_e   (mm_e),
    .mm_wr  (mm_wr),
    .mm_a   (mm_a),
    .mm_cu  (mm_cu),
    .mm_n_i (mm_n_i),
    .mm_n_o (mm_n_o),
    .mm_ok  (mm_ok),
    .ram_a  (ram_a),
    .ram_d  (ram_d),
    .ram_wr (ram_wr),
    .ram_q  (ram_q)
  );

  // Byte RAM model: 4 KiB window on ram_a[11:0], one-cycle read latency.
  logic [7:0] mem [4096];
  logic       init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'h11;
      mem[12'h101] <= 8'h22;
      mem[12'h102] <= 8'h33;
      mem[12'h103] <= 8'h44;
      mem[12'hFFE] <= 8'hA1;
      mem[12'hFFF] <= 8'hB2;
      mem[12'h000] <= 8'hC3;
      mem[12'h001] <= 8'hD4;
    end else if (ram_wr) begin
      mem[ram_a[11:0]] <= ram_d;
    end
    ram_q <= mem[ram_a[11:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [31:0] trace_a [4];
  logic [3:0]  trace_wr;

  // Issues one request at a negedge, drops it after acceptance, and returns the
  // cycle on which the owner's ok appeared (-1 if it never did).
  task automatic run_req(input logic use_if, input logic wr, input logic [1:0] cu,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] q, output int wrong_ok);
    lat      = -1;
    q        = '0;
    wrong_ok = 0;
    if (use_if) begin
      if_e = 1'b1;
      if_a = a;
    end else begin
      mm_e   = 1'b1;
      mm_wr  = wr;
      mm_cu  = cu;
      mm_a   = a;
      mm_n_i = d;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if_e = 1'b0;
        mm_e = 1'b0;
      end
      if (c <= 4) begin
        trace_a[c-1]  = ram_a;
        trace_wr[c-1] = ram_wr;
      end
      if (use_if ? mm_ok : if_ok) wrong_ok++;
      if (use_if ? if_ok : mm_ok) begin
        lat = c;
        q   = use_if ? if_n_o : mm_n_o;
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  cu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_q;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat;
    int          wrong;
    logic [31:0] q;
    int          mm_cyc;
    int          if_cyc;
    int          n_mm;
    int          n_if;
    int          n_wr;

    vecs[0]  = '{1'b1, 2'd1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,          3, "st_half_200"};
    vecs[1]  = '{1'b0, 2'd0, 32'h0000_0200, 32'h0,          32'h0000_00EF, 3, "ld_byte_200"};
    vecs[2]  = '{1'b0, 2'd1, 32'h0000_0200, 32'h0,          32'h0000_BEEF, 4, "ld_half_200"};
    vecs[3]  = '{1'b1, 2'd3, 32'h0000_0300, 32'h1234_5678, 32'h0,          5, "st_word_300"};
    vecs[4]  = '{1'b0, 2'd3, 32'h0000_0300, 32'h0,          32'h1234_5678, 6, "ld_word_300"};
    vecs[5]  = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,          32'h0034_5678, 5, "ld_tri_300"};
    vecs[6]  = '{1'b1, 2'd0, 32'h0000_0301, 32'hFFFF_FFAA, 32'h0,          2, "st_byte_301"};
    vecs[7]  = '{1'b0, 2'd3, 32'h0000_0300, 32'h0,          32'h1234_AA78, 6, "ld_word_300b"};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,          4, "st_tri_400"};
    vecs[9]  = '{1'b0, 2'd3, 32'h0000_0400, 32'h0,          32'h00FE_F00D, 6, "ld_word_400"};
    vecs[10] = '{1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,          32'hD4C3_B2A1, 6, "ld_word_wrap"};

    rst = 1'b1; init_mem = 1'b1;
    if_e = 1'b0; if_a = '0;
    mm_e = 1'b0; mm_wr = 1'b0; mm_a = '0; mm_cu = '0; mm_n_i = '0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;

    check("rst_if_ok",  {31'd0, if_ok},  32'd0);
    check("rst_mm_ok",  {31'd0, mm_ok},  32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_a",  ram_a,           32'd0);
    check("rst_ram_d",  {24'd0, ram_d},  32'd0);
    check("rst_if_n_o", if_n_o,          32'd0);
    check("rst_mm_n_o", mm_n_o,          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Instruction fetch of a full word.
    run_req(1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0, lat, q, wrong);
    check("fetch_lat",   32'(lat), 32'd6);
    check("fetch_data",  q,        32'h4433_2211);
    check("fetch_other_ok", 32'(wrong), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("fetch_ram_a%0d", i), trace_a[i], 32'h100 + 32'(i));
    check("fetch_ram_wr", {28'd0, trace_wr}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      run_req(1'b0, vecs[v].wr, vecs[v].cu, vecs[v].addr, vecs[v].wdata, lat, q, wrong);
      check({vecs[v].name, "_lat"}, 32'(lat), 32'(vecs[v].exp_lat));
      check({vecs[v].name, "_other_ok"}, 32'(wrong), 32'd0);
      if (!vecs[v].wr) check({vecs[v].name, "_data"}, q, vecs[v].exp_q);
    end

    check("wrap_ram_a0", trace_a[0], 32'hFFFF_FFFE);
    check("wrap_ram_a1", trace_a[1], 32'hFFFF_FFFF);
    check("wrap_ram_a2", trace_a[2], 32'h0000_0000);
    check("wrap_ram_a3", trace_a[3], 32'h0000_0001);
    check("mem_200", {24'd0, mem[12'h200]}, 32'hEF);
    check("mem_201", {24'd0, mem[12'h201]}, 32'hBE);
    check("mem_202", {24'd0, mem[12'h202]}, 32'h00);
    check("mem_403", {24'd0, mem[12'h403]}, 32'h00);
    repeat (3) @(negedge clk);
    check("mm_n_o_hold", mm_n_o, 32'hD4C3_B2A1);
    check("if_n_o_hold", if_n_o, 32'h4433_2211);

    // Both requesters in the same IDLE cycle: MM first, IF right after.
    mm_e = 1'b1; mm_wr = 1'b0; mm_cu = 2'd0; mm_a = 32'h200;
    if_e = 1'b1; if_a = 32'h100;
    mm_cyc = -1; if_cyc = -1; n_mm = 0; n_if = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) mm_e = 1'b0;
      if (c == 5) if_e = 1'b0;
      if (mm_ok) begin
        n_mm++;
        if (mm_cyc < 0) mm_cyc = c;
      end
      if (if_ok) begin
        n_if++;
        if (if_cyc < 0) if_cyc = c;
      end
    end
    check("arb_mm_cycle", 32'(mm_cyc), 32'd3);
    check("arb_if_cycle", 32'(if_cyc), 32'd10);
    check("arb_mm_pulses", 32'(n_mm), 32'd1);
    check("arb_if_pulses", 32'(n_if), 32'd1);
    check("arb_mm_data", mm_n_o, 32'h0000_00EF);

    // Reset during the second byte of a word store.
    mm_e = 1'b1; mm_wr = 1'b1; mm_cu = 2'd3; mm_a = 32'h500; mm_n_i = 32'h9988_7766;
    @(negedge clk);
    mm_e = 1'b0;
    @(negedge clk);
    check("rstx_wr_before", {31'd0, ram_wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstx_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rstx_ram_a",  ram_a,  32'd0);
    check("rstx_mm_n_o", mm_n_o, 32'd0);
    rst = 1'b0;
    n_mm = 0; n_wr = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mm_ok)  n_mm++;
      if (ram_wr) n_wr++;
    end
    check("rstx_no_ok", 32'(n_mm), 32'd0);
    check("rstx_no_wr", 32'(n_wr), 32'd0);
    check("rstx_mem_500", {24'd0, mem[12'h500]}, 32'h66);
    check("rstx_mem_501", {24'd0, mem[12'h501]}, 32'h77);
    check("rstx_mem_502", {24'd0, mem[12'h502]}, 32'h00);
    check("rstx_mem_503", {24'd0, mem[12'h503]}, 32'h00);
    run_req(1'b0, 1'b0, 2'd0, 32'h0000_0500, 32'h0, lat, q, wrong);
    check("rstx_reload_lat",  32'(lat), 32'd3);
    check("rstx_reload_data", q,        32'h0000_0066);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
